// File: rtl/video_pkg.sv
// Shared encodings for the test-pattern sequencer: pattern IDs, FSM states,
// request directions and the wrap-around pattern stepping rule.
package video_pkg;

  typedef enum logic [2:0] {
    PAT_SMPTE_BARS = 3'd0,
    PAT_GRID       = 3'd1,
    PAT_SOLID      = 3'd2,
    PAT_GRADIENT   = 3'd3
  } pattern_e;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  typedef enum logic {
    NEXT = 1'b0,
    PREV = 1'b1
  } dir_e;

  // Neighbouring pattern with wrap; last is the highest valid index.
  function automatic logic [2:0] step_pattern(input logic [2:0] sel,
                                              input dir_e       dir,
                                              input logic [2:0] last);
    if (dir == NEXT) begin
      return (sel == last) ? 3'd0 : sel + 3'd1;
    end
    return (sel == 3'd0) ? last : sel - 3'd1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_debouncer.sv
// Button debouncer: 2-flop synchroniser, stable-sample counter and a
// one-cycle press event on each accepted 0->1 transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Only an accepted rising level produces an event; release is silent.
        level <= sync_b;
        cnt   <= '0;
        press <= sync_b;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: button/auto requests are served
// on frame boundaries, each switch preceded by a run of blanked frames.
module pattern_sequencer
  import video_pkg::*;
#(
  parameter int NUM_PATTERNS    = 4,
  parameter int AUTO_FRAMES     = 120,
  parameter int BLANK_FRAMES    = 2,
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [2:0] pattern_sel,
  output logic       blank,
  output logic       change_pulse
);

  localparam logic [2:0] LAST_PAT   = 3'(NUM_PATTERNS - 1);
  localparam logic [7:0] AUTO_LAST  = 8'(AUTO_FRAMES - 1);
  localparam logic [3:0] BLANK_LAST = 4'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

  logic       frame_tick;
  logic       next_evt;
  logic       prev_evt;
  logic       pending;
  dir_e       dir;
  logic [7:0] auto_cnt;
  logic       auto_req;
  logic       req_valid;
  dir_e       req_dir;
  logic [2:0] target;
  logic [3:0] blank_cnt;
  state_e     state;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .press (next_evt)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_prev),
    .press (prev_evt)
  );

  assign frame_tick = (hpos == 9'd0) && (vpos == 9'd0);

  // An auto request can only fire when nothing is pending, so it is served
  // on the very tick that raises it; a latched button request wins otherwise.
  assign auto_req  = frame_tick && (state == SHOW) && auto_en && !pending &&
                     (auto_cnt == AUTO_LAST);
  assign req_valid = pending || auto_req;
  assign req_dir   = pending ? dir : NEXT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= SHOW;
      pattern_sel  <= PAT_SMPTE_BARS;
      blank        <= 1'b0;
      change_pulse <= 1'b0;
      target       <= '0;
      blank_cnt    <= '0;
      auto_cnt     <= '0;
      pending      <= 1'b0;
      dir          <= NEXT;
    end else begin
      change_pulse <= 1'b0;

      if (!auto_en || (state == BLANK) || change_pulse) begin
        auto_cnt <= '0;
      end else if (frame_tick && !pending) begin
        auto_cnt <= (auto_cnt == AUTO_LAST) ? 8'd0 : auto_cnt + 8'd1;
      end

      case (state)
        SHOW: begin
          if (frame_tick && req_valid) begin
            pending <= 1'b0;
            if (BLANK_FRAMES > 0) begin
              target    <= step_pattern(pattern_sel, req_dir, LAST_PAT);
              blank     <= 1'b1;
              blank_cnt <= '0;
              state     <= BLANK;
            end else begin
              pattern_sel  <= step_pattern(pattern_sel, req_dir, LAST_PAT);
              change_pulse <= 1'b1;
            end
          end
        end
        BLANK: begin
          if (frame_tick) begin
            if (blank_cnt == BLANK_LAST) begin
              pattern_sel  <= target;
              blank        <= 1'b0;
              change_pulse <= 1'b1;
              state        <= SHOW;
            end else begin
              blank_cnt <= blank_cnt + 4'd1;
            end
          end
        end
        default: state <= SHOW;
      endcase

      // Placed after the FSM so a press landing on the serving tick survives.
      if (next_evt && !prev_evt) begin
        pending <= 1'b1;
        dir     <= NEXT;
      end else if (prev_evt && !next_evt) begin
        pending <= 1'b1;
        dir     <= PREV;
      end
    end
  end

endmodule
